// File: rtl/rhs_seq_ctrl.sv
// Frame sequencer for two RHS stimulation/recording chips sharing one SPI master.
// Optional WAIT_RX watchdog is enabled by defining RHS_SEQ_TIMEOUT_EN.
module rhs_seq_ctrl #(
  parameter int WORD_LENGTH = 32,
  parameter int N_CH        = 16,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   continuous,
  input  logic                   stop,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err,
  output logic                   spi_data_v,
  input  logic                   spi_ready,
  input  logic                   spi_data_out_v,
  output logic [WORD_LENGTH-1:0] spi_cmd_1,
  output logic [WORD_LENGTH-1:0] spi_cmd_2,
  input  logic [WORD_LENGTH-1:0] spi_rx_1,
  input  logic [WORD_LENGTH-1:0] spi_rx_2,
  output logic                   sample_v,
  output logic [3:0]             sample_ch,
  output logic [15:0]            sample_1,
  output logic [15:0]            sample_2
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_RX = 2'd2,
    S_EMIT    = 2'd3
  } state_t;

  localparam logic [4:0]             LAST_SLOT = 5'(N_CH + 1);
  localparam logic [WORD_LENGTH-1:0] FLUSH_CMD = WORD_LENGTH'(32'hC0FF_0000);

  // Slots below N_CH convert their own channel; the two trailing slots flush the pipeline.
  function automatic logic [WORD_LENGTH-1:0] slot_cmd(input logic [4:0] slot);
    logic [WORD_LENGTH-1:0] cmd;
    if (slot < 5'(N_CH)) begin
      cmd = WORD_LENGTH'({10'd0, 1'b0, slot, 16'd0});
    end else begin
      cmd = FLUSH_CMD;
    end
    return cmd;
  endfunction

  state_t                   state_q;
  logic [4:0]               slot_q;
  logic                     stop_q;
  logic                     busy_q;
  logic                     frame_done_q;
  logic                     spi_data_v_q;
  logic [WORD_LENGTH-1:0]   spi_cmd_q;
  logic                     sample_v_q;
  logic [3:0]               sample_ch_q;
  logic [15:0]              sample_1_q;
  logic [15:0]              sample_2_q;

`ifdef RHS_SEQ_TIMEOUT_EN
  localparam int             WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);
  logic [WD_W-1:0] wd_cnt_q;
  logic            err_q;
`endif

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      slot_q       <= 5'd0;
      stop_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      spi_data_v_q <= 1'b0;
      spi_cmd_q    <= '0;
      sample_v_q   <= 1'b0;
      sample_ch_q  <= 4'd0;
      sample_1_q   <= 16'd0;
      sample_2_q   <= 16'd0;
`ifdef RHS_SEQ_TIMEOUT_EN
      wd_cnt_q     <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      sample_v_q   <= 1'b0;
`ifdef RHS_SEQ_TIMEOUT_EN
      err_q        <= 1'b0;
`endif
      if (state_q != S_IDLE && stop) begin
        stop_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q      <= S_ISSUE;
            slot_q       <= 5'd0;
            busy_q       <= 1'b1;
            spi_data_v_q <= 1'b1;
            spi_cmd_q    <= slot_cmd(5'd0);
          end
        end
        S_ISSUE: begin
          if (spi_ready) begin
            state_q      <= S_WAIT_RX;
            spi_data_v_q <= 1'b0;
`ifdef RHS_SEQ_TIMEOUT_EN
            wd_cnt_q     <= '0;
`endif
          end
        end
        S_WAIT_RX: begin
          if (spi_data_out_v) begin
            state_q <= S_EMIT;
            // Results lag commands by two slots, so the first two responses are discarded.
            if (slot_q >= 5'd2) begin
              sample_v_q   <= 1'b1;
              sample_ch_q  <= 4'(slot_q - 5'd2);
              sample_1_q   <= spi_rx_1[15:0];
              sample_2_q   <= spi_rx_2[15:0];
              frame_done_q <= (slot_q == LAST_SLOT);
            end
          end
`ifdef RHS_SEQ_TIMEOUT_EN
          else if (wd_cnt_q == WD_LIMIT) begin
            state_q <= S_IDLE;
            slot_q  <= 5'd0;
            busy_q  <= 1'b0;
            stop_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            wd_cnt_q <= wd_cnt_q + WD_W'(1);
          end
`endif
        end
        S_EMIT: begin
          if (slot_q != LAST_SLOT) begin
            state_q      <= S_ISSUE;
            slot_q       <= slot_q + 5'd1;
            spi_data_v_q <= 1'b1;
            spi_cmd_q    <= slot_cmd(slot_q + 5'd1);
          end else if (continuous && !stop_q && !stop) begin
            state_q      <= S_ISSUE;
            slot_q       <= 5'd0;
            spi_data_v_q <= 1'b1;
            spi_cmd_q    <= slot_cmd(5'd0);
          end else begin
            state_q <= S_IDLE;
            slot_q  <= 5'd0;
            busy_q  <= 1'b0;
            stop_q  <= 1'b0;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          slot_q       <= 5'd0;
          busy_q       <= 1'b0;
          stop_q       <= 1'b0;
          spi_data_v_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign spi_data_v = spi_data_v_q;
  assign spi_cmd_1  = spi_cmd_q;
  assign spi_cmd_2  = spi_cmd_q;
  assign sample_v   = sample_v_q;
  assign sample_ch  = sample_ch_q;
  assign sample_1   = sample_1_q;
  assign sample_2   = sample_2_q;

`ifdef RHS_SEQ_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Upper response bits carry no ADC data.
  logic unused_s;
  assign unused_s = ^{spi_rx_1[WORD_LENGTH-1:16], spi_rx_2[WORD_LENGTH-1:16], 32'(TIMEOUT)};

endmodule
